if_id_buffer: RTL

//  IF/ID pipeline buffer directly downstream of the fetch stage. Registers the
//  64-bit fetch bundle, assembles two-word (instruction + 16-bit immediate)

---
 rtl/if_id_buffer.sv | 81 ++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: registers the fetch bundle, merges an instruction with its
// trailing 16-bit immediate into one decode packet, and emits bubbles on flush or partial.
module if_id_buffer #(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [63:0]      In,
  input  logic             Stall,
  input  logic             Flush,
  output logic [80:0]      Out,
  output logic             Busy,
  output logic [CNT_W-1:0] PktCount
);

  // Handshake: no valid/ready. Out[80] marks a packet for exactly the cycle it is
  // registered; Stall freezes everything, so decode may re-read Out while stalled.
  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_IMM = 1'b1
  } state_t;

  state_t           r_state;
  logic [15:0]      r_hold_instr;
  logic [15:0]      r_hold_aux;
  logic [80:0]      r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [15:0] w_word;
  logic [31:0] w_pc_next;
  logic [15:0] w_aux;
  logic [80:0] w_bubble;

  assign w_word    = In[15:0];
  assign w_pc_next = In[47:16];
  assign w_aux     = In[63:48];
  assign w_bubble  = {1'b0, NOP_INSTR, 64'h0};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_out        <= w_bubble;
      r_hold_instr <= 16'h0;
      r_hold_aux   <= 16'h0;
      r_cnt        <= '0;
    end else if (Flush) begin
      // A held first word is dropped; the packet count is left alone.
      r_state      <= S_IDLE;
      r_out        <= w_bubble;
      r_hold_instr <= 16'h0;
      r_hold_aux   <= 16'h0;
    end else if (!Stall) begin
      case (r_state)
        S_IDLE: begin
          if (w_word[15]) begin
            r_hold_instr <= w_word;
            r_hold_aux   <= w_aux;
            r_out        <= w_bubble;
            r_state      <= S_WAIT_IMM;
          end else begin
            r_out <= {1'b1, w_word, 16'h0, w_pc_next, w_aux};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_IMM: begin
          // The incoming word is the immediate, regardless of its bit 15.
          r_out   <= {1'b1, r_hold_instr, w_word, w_pc_next, r_hold_aux};
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out      = r_out;
  assign Busy     = (r_state == S_WAIT_IMM);
  assign PktCount = r_cnt;

endmodule
